// File: rtl/credit_return_mw_if.sv
// Request / table / output bus of the multi-word credit-return path.
// master: request source, table models and sink. slave: credit_return_mw.
interface credit_return_mw_if #(
  parameter int DATA_W     = 16,
  parameter int WORDS      = 16,
  parameter int ADDR_W     = 8,
  parameter int FIFO_WORDS = 64
);
  localparam int CNT_W = $clog2(WORDS);
  localparam int CRD_W = $clog2(FIFO_WORDS) + 1;

  logic [ADDR_W-1:0]       in_tdata;
  logic                    in_tvalid;
  logic                    in_tready;
  logic [ADDR_W-1:0]       rd_a_addr;
  logic                    rd_a_read;
  logic [CNT_W+ADDR_W-1:0] rd_a_data;
  logic                    rd_a_valid;
  logic [ADDR_W-1:0]       rd_b_addr;
  logic                    rd_b_read;
  logic [WORDS*DATA_W-1:0] rd_b_data;
  logic                    rd_b_valid;
  logic [DATA_W-1:0]       out_tdata;
  logic                    out_tvalid;
  logic                    out_tready;
  logic [CRD_W-1:0]        crd_level;
  logic                    err;

  modport master (
    output in_tdata, in_tvalid, rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, out_tready,
    input  in_tready, rd_a_addr, rd_a_read, rd_b_addr, rd_b_read, out_tdata, out_tvalid,
           crd_level, err
  );

  modport slave (
    input  in_tdata, in_tvalid, rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, out_tready,
    output in_tready, rd_a_addr, rd_a_read, rd_b_addr, rd_b_read, out_tdata, out_tvalid,
           crd_level, err
  );
endinterface

// File: rtl/credit_return_mw.sv
// Credit-return path: index -> table A {size, line addr} -> table B line ->
// multi-word-write FIFO -> one word per cycle. A full line of credit is
// reserved on accept and the unused part refunded when the size is known.
module credit_return_mw #(
  parameter int DATA_W     = 16,
  parameter int WORDS      = 16,
  parameter int ADDR_W     = 8,
  parameter int FIFO_WORDS = 64,
  parameter int MAX_OUTST  = 4
) (
  input  logic             aclk,
  input  logic             reset_p,
  credit_return_mw_if.slave bus
);
  localparam int CNT_W = $clog2(WORDS);
  localparam int PTR_W = $clog2(FIFO_WORDS);
  localparam int CRD_W = PTR_W + 1;
  localparam int TQ_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [CRD_W-1:0] WORDS_C = CRD_W'(WORDS);
  localparam logic [CRD_W-1:0] FIFO_C  = CRD_W'(FIFO_WORDS);

  logic [CRD_W-1:0]  crd_q, crd_d;
  logic              acc, pop;
  logic [CNT_W-1:0]  a_sz;
  logic [CNT_W:0]    a_n, b_n;

  logic [CNT_W:0]    tq_mem_q [MAX_OUTST];
  logic [TQ_W-1:0]   tq_wr_q, tq_rd_q;
  logic [TQ_W:0]     tq_cnt_q;
  logic              tq_push, tq_pop, tq_full, tq_empty;

  logic [DATA_W-1:0] mem_q [FIFO_WORDS];
  logic [CRD_W-1:0]  wr_q, rd_q, occ, free;
  logic              wr_en, wr_ovf;
  logic              err_q;

  // Pass-through strobes and addresses to the external tables
  assign bus.in_tready = (crd_q >= WORDS_C);
  assign acc           = bus.in_tvalid & bus.in_tready;
  assign bus.rd_a_addr = bus.in_tdata;
  assign bus.rd_a_read = acc;
  assign bus.rd_b_addr = bus.rd_a_data[ADDR_W-1:0];
  assign bus.rd_b_read = bus.rd_a_valid;

  // Size 0 encodes a full line
  assign a_sz = bus.rd_a_data[CNT_W+ADDR_W-1:ADDR_W];
  assign a_n  = (a_sz == '0) ? (CNT_W+1)'(WORDS) : {1'b0, a_sz};

  // Tag queue carries each line's word count from table A to table B
  assign tq_full  = (tq_cnt_q == (TQ_W+1)'(MAX_OUTST));
  assign tq_empty = (tq_cnt_q == '0);
  assign tq_pop   = bus.rd_b_valid & ~tq_empty;
  assign tq_push  = bus.rd_a_valid & (~tq_full | tq_pop);
  assign b_n      = tq_mem_q[tq_rd_q];

  // FIFO status; pointers carry one wrap bit
  assign occ            = wr_q - rd_q;
  assign free           = FIFO_C - occ;
  assign wr_en          = tq_pop & (CRD_W'(b_n) <= free);
  assign wr_ovf         = tq_pop & ~wr_en;
  assign bus.out_tvalid = (wr_q != rd_q);
  assign bus.out_tdata  = mem_q[rd_q[PTR_W-1:0]];
  assign pop            = bus.out_tvalid & bus.out_tready;

  assign bus.crd_level = crd_q;
  assign bus.err       = err_q;

  // Credit next state: reserve on accept, refund unused words, return on pop
  always_comb begin
    crd_d = crd_q;
    if (acc)            crd_d = crd_d - WORDS_C;
    if (bus.rd_a_valid) crd_d = crd_d + (WORDS_C - CRD_W'(a_n));
    if (pop)            crd_d = crd_d + CRD_W'(1);
  end

  // Control state: credits, tag queue pointers, FIFO pointers, sticky error
  always_ff @(posedge aclk) begin
    if (reset_p) begin
      crd_q    <= FIFO_C;
      tq_wr_q  <= '0;
      tq_rd_q  <= '0;
      tq_cnt_q <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      crd_q <= crd_d;
      if (tq_push) tq_wr_q <= (tq_wr_q == TQ_W'(MAX_OUTST-1)) ? '0 : tq_wr_q + TQ_W'(1);
      if (tq_pop)  tq_rd_q <= (tq_rd_q == TQ_W'(MAX_OUTST-1)) ? '0 : tq_rd_q + TQ_W'(1);
      tq_cnt_q <= tq_cnt_q + (TQ_W+1)'(tq_push) - (TQ_W+1)'(tq_pop);
      if (wr_en) wr_q <= wr_q + CRD_W'(b_n);
      if (pop)   rd_q <= rd_q + CRD_W'(1);
      if ((bus.rd_b_valid & tq_empty) | (bus.rd_a_valid & ~tq_push) | wr_ovf)
        err_q <= 1'b1;
    end
  end

  // Tag storage; no reset needed, validity comes from the counters
  always_ff @(posedge aclk) begin
    if (tq_push) tq_mem_q[tq_wr_q] <= a_n;
  end

  // Multi-word write of words 0..n-1 starting at wr_ptr, wrapping modulo depth
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      for (int k = 0; k < WORDS; k++) begin
        if ((CNT_W+1)'(k) < b_n)
          mem_q[wr_q[PTR_W-1:0] + PTR_W'(k)] <= bus.rd_b_data[k*DATA_W +: DATA_W];
      end
    end
  end
endmodule

// File: tb/tb_credit_return_mw.sv
// Randomized bench for credit_return_mw. Table A/B are modelled here; the
// reference tracks reserved lines, pending lines and expected words with queues
// and derives credits from the conservation rule.
module tb_credit_return_mw;
  localparam int DATA_W = 16, WORDS = 16, ADDR_W = 8, FIFO_WORDS = 64, MAX_OUTST = 4;
  localparam int CNT_W = $clog2(WORDS);

  typedef struct { int n; int laddr; int due; } bent_t;

  logic aclk = 1'b0;
  logic reset_p;
  always #5 aclk = ~aclk;

  credit_return_mw_if #(.DATA_W(DATA_W), .WORDS(WORDS), .ADDR_W(ADDR_W),
                        .FIFO_WORDS(FIFO_WORDS)) bus ();

  credit_return_mw #(.DATA_W(DATA_W), .WORDS(WORDS), .ADDR_W(ADDR_W),
                     .FIFO_WORDS(FIFO_WORDS), .MAX_OUTST(MAX_OUTST)) dut (
    .aclk(aclk), .reset_p(reset_p), .bus(bus));

  logic [CNT_W+ADDR_W-1:0] ta  [256];
  logic [WORDS*DATA_W-1:0] tbm [256];

  int          pend_a[$];
  bent_t       pend_b[$];
  logic [15:0] exp_q[$];
  bit          exp_err;
  int          last_due, cyc;
  int          n_chk = 0, n_err = 0;
  int          a_pct = 75;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int m_crd();
    int r;
    r = FIFO_WORDS - WORDS * pend_a.size() - exp_q.size();
    foreach (pend_b[i]) r -= pend_b[i].n;
    return r;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_crd"},  64'(bus.crd_level), 64'(m_crd()));
    chk({tag, "_oval"}, 64'(bus.out_tvalid), 64'(exp_q.size() != 0));
    chk({tag, "_err"},  64'(bus.err), 64'(exp_err));
  endtask

  task automatic idle_inputs();
    bus.in_tvalid = 1'b0; bus.in_tdata = '0; bus.rd_a_valid = 1'b0; bus.rd_a_data = '0;
    bus.rd_b_valid = 1'b0; bus.rd_b_data = '0; bus.out_tready = 1'b0;
  endtask

  // Starts and ends at a negedge
  task automatic do_reset();
    reset_p = 1'b1;
    idle_inputs();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    reset_p = 1'b0;
    pend_a.delete(); pend_b.delete(); exp_q.delete();
    exp_err = 1'b0; last_due = 0;
    chk_state("rst");
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model, check state
  task automatic step(input bit req, input logic [7:0] idx, input bit ordy, input bit spur);
    bit m_rdy, a_fire, b_fire, pop;
    int lat, la, sz, n;
    m_rdy  = (m_crd() >= WORDS);
    a_fire = (pend_a.size() != 0) && (pend_b.size() < MAX_OUTST) &&
             ($urandom_range(0, 99) < a_pct);
    b_fire = (pend_b.size() != 0) && (pend_b[0].due <= cyc);
    pop    = (exp_q.size() != 0) && ordy;

    bus.in_tvalid  = req;
    bus.in_tdata   = idx;
    bus.out_tready = ordy;
    bus.rd_a_valid = a_fire;
    bus.rd_a_data  = a_fire ? ta[pend_a[0]] : '0;
    bus.rd_b_valid = b_fire | spur;
    if (b_fire) bus.rd_b_data = tbm[pend_b[0].laddr];
    else for (int k = 0; k < WORDS; k++) bus.rd_b_data[k*DATA_W +: DATA_W] = 16'($urandom);
    #1;
    chk("in_tready", 64'(bus.in_tready), 64'(m_rdy));
    chk("a_read", 64'(bus.rd_a_read), 64'(req & m_rdy));
    if (req) chk("a_addr", 64'(bus.rd_a_addr), 64'(idx));
    chk("b_read", 64'(bus.rd_b_read), 64'(a_fire));
    if (a_fire) chk("b_addr", 64'(bus.rd_b_addr), 64'(ta[pend_a[0]][ADDR_W-1:0]));
    if (exp_q.size() != 0) chk("tdata", 64'(bus.out_tdata), 64'(exp_q[0]));

    if (pop) void'(exp_q.pop_front());
    if (b_fire) begin
      la = pend_b[0].laddr; n = pend_b[0].n;
      void'(pend_b.pop_front());
      for (int k = 0; k < n; k++) exp_q.push_back(tbm[la][k*DATA_W +: DATA_W]);
    end else if (spur && pend_b.size() == 0) begin
      exp_err = 1'b1;
    end
    if (a_fire) begin
      la  = int'(ta[pend_a[0]][ADDR_W-1:0]);
      sz  = int'(ta[pend_a[0]][CNT_W+ADDR_W-1:ADDR_W]);
      lat = cyc + $urandom_range(1, MAX_OUTST);
      if (lat <= last_due) lat = last_due + 1;
      last_due = lat;
      void'(pend_a.pop_front());
      pend_b.push_back('{n: (sz == 0) ? WORDS : sz, laddr: la, due: lat});
    end
    if (req && m_rdy) pend_a.push_back(int'(idx));

    @(posedge aclk);
    cyc++;
    @(negedge aclk);
    idle_inputs();
    chk_state("cyc");
  endtask

  initial begin
    cyc = 0;
    for (int a = 0; a < 256; a++) begin
      ta[a] = {4'($urandom), 8'($urandom)};
      for (int k = 0; k < WORDS; k++) tbm[a][k*DATA_W +: DATA_W] = 16'($urandom);
    end
    ta[5] = {4'h0, 8'h3C};
    ta[7] = {4'h3, 8'h21};
    @(negedge aclk);
    do_reset();
    chk("rst_ready", 64'(bus.in_tready), 64'd1);

    // Single full line
    step(1'b1, 8'h05, 1'b1, 1'b0);
    repeat (30) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_crd", 64'(bus.crd_level), 64'd64);

    // Short line: reserve 16, refund 13
    a_pct = 0;
    step(1'b1, 8'h07, 1'b1, 1'b0);
    chk("t2_acc", 64'(bus.crd_level), 64'd48);
    a_pct = 100;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t2_refund", 64'(bus.crd_level), 64'd61);
    a_pct = 75;
    repeat (20) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_crd", 64'(bus.crd_level), 64'd64);

    // Back-pressure with four full lines
    repeat (4) step(1'b1, 8'h05, 1'b0, 1'b0);
    chk("t3_closed", 64'(bus.in_tready), 64'd0);
    repeat (20) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_one_pop", 64'(bus.in_tready), 64'd0);
    repeat (15) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_reopen", 64'(bus.in_tready), 64'd1);
    repeat (60) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Spurious table-B response: sticky error, FIFO untouched, reset clears
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t6_err", 64'(bus.err), 64'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_sticky", 64'(bus.err), 64'd1);
    chk("t6_empty", 64'(bus.out_tvalid), 64'd0);
    do_reset();

    // Random traffic with a reset mid-stream
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) != 0, 1'b0);
    end
    repeat (100) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_drain_crd", 64'(bus.crd_level), 64'd64);
    chk("t4_err", 64'(bus.err), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
